// File: rtl/sort_out_serializer.sv
// sort_out_serializer: buffers sorted 4-element groups in a small circular
// FIFO and emits them one element per accepted cycle (valid/ready output).
// Optional macro SORT_OUT_SERIALIZER_ORDER_CHECK_EN enables the sticky
// order_err detector for unsorted input groups.
module sort_out_serializer #(
    parameter int p_nbits = 8,
    parameter int p_depth = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    input  logic [p_nbits-1:0]           in0,
    input  logic [p_nbits-1:0]           in1,
    input  logic [p_nbits-1:0]           in2,
    input  logic [p_nbits-1:0]           in3,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [p_nbits-1:0]           out_msg,
    output logic [1:0]                   out_idx,
    output logic                         out_last,
    output logic [$clog2(p_depth):0]     count,
    output logic                         overflow,
    output logic                         order_err
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth) + 1;

    logic [p_nbits-1:0] mem [p_depth][4];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic [1:0]         idx;
    logic               ovf;
    logic               full;
    logic               pop;
    logic               push;
    logic               has_data;

    // Handshake decode: a completing pop frees a slot for a same-cycle push
    always_comb begin
        full     = (cnt == CW'(p_depth));
        has_data = (cnt != '0);
        pop      = has_data & out_rdy & (idx == 2'd3);
        push     = in_val & (~full | pop);
    end

    // Group storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr][0] <= in0;
            mem[wr_ptr][1] <= in1;
            mem[wr_ptr][2] <= in2;
            mem[wr_ptr][3] <= in3;
        end
    end

    // Pointers, occupancy, element index and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            idx    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push & ~pop)
                cnt <= cnt + CW'(1);
            else if (pop & ~push)
                cnt <= cnt - CW'(1);
            if (has_data & out_rdy)
                idx <= idx + 2'd1;
            if (in_val & full & ~pop)
                ovf <= 1'b1;
        end
    end

    // Output presentation; all zeros while nothing is buffered
    always_comb begin
        out_val  = has_data;
        out_msg  = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (has_data) begin
            out_msg  = mem[rd_ptr][idx];
            out_idx  = idx;
            out_last = (idx == 2'd3);
        end
        count    = cnt;
        overflow = ovf;
    end

`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
    logic unsorted;

    // Unsigned neighbour comparison of the incoming group
    always_comb begin
        unsorted = (in0 > in1) | (in1 > in2) | (in2 > in3);
    end

    // Sticky order error, also raised for groups dropped on overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            order_err <= 1'b0;
        else if (in_val & unsorted)
            order_err <= 1'b1;
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
// tb_sort_out_serializer: directed scoreboard bench for sort_out_serializer.
module tb_sort_out_serializer;

    localparam int NB = 8;
    localparam int DEPTH = 2;

`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
    localparam logic EXP_OE = 1'b1;
`else
    localparam logic EXP_OE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic [NB-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] out_msg;
    logic [1:0]    out_idx;
    logic          out_last;
    logic [$clog2(DEPTH):0] count;
    logic          overflow;
    logic          order_err;

    int total = 0;
    int bad = 0;

    // expected entry: {msg, idx, last}
    logic [NB+2:0] exp_q[$];

    sort_out_serializer #(.p_nbits(NB), .p_depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_val(in_val),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .out_idx(out_idx), .out_last(out_last), .count(count),
        .overflow(overflow), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one group for one edge; queue its elements if it should be accepted
    task automatic send_group(input logic [NB-1:0] a, b, c, d, input bit accept);
        in_val = 1'b1;
        in0 = a; in1 = b; in2 = c; in3 = d;
        if (accept) begin
            exp_q.push_back({a, 2'd0, 1'b0});
            exp_q.push_back({b, 2'd1, 1'b0});
            exp_q.push_back({c, 2'd2, 1'b0});
            exp_q.push_back({d, 2'd3, 1'b1});
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        in0 = 'x; in1 = 'x; in2 = 'x; in3 = 'x;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted element against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {out_msg, out_idx, out_last}, 32'hFFFF_FFFF);
                end else begin
                    logic [NB+2:0] e;
                    e = exp_q.pop_front();
                    check("out_element", {21'd0, out_msg, out_idx, out_last}, {21'd0, e});
                end
            end else if (!out_val) begin
                check("idle_outputs_zero", {21'd0, out_msg, out_idx, out_last}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset state
        #3;
        check("rst_out_val", out_val, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_order_err", order_err, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_idx", out_idx, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        cycles(1);

        // single group, always ready
        out_rdy = 1'b1;
        send_group(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        check("single_val_rise", out_val, 1);
        check("single_first_msg", out_msg, 8'h01);
        cycles(3);
        check("single_last", out_last, 1);
        cycles(1);
        check("single_val_fall", out_val, 0);
        check("single_count_zero", count, 0);

        // back-to-back groups under backpressure, then gapless drain
        out_rdy = 1'b0;
        send_group(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        send_group(8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
        cycles(10);
        check("stall_count", count, 2);
        check("stall_msg", out_msg, 8'h10);
        check("stall_idx", out_idx, 0);
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_no_gap", out_val, 1);
            cycles(1);
        end
        check("drain_empty", out_val, 0);

        // overflow: third group dropped
        out_rdy = 1'b0;
        send_group(8'h11, 8'h12, 8'h13, 8'h14, 1'b1);
        send_group(8'h21, 8'h22, 8'h23, 8'h24, 1'b1);
        check("ovf_before", overflow, 0);
        send_group(8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 2);
        check("ovf_head", out_msg, 8'h11);
        out_rdy = 1'b1;
        cycles(9);
        check("ovf_drained", out_val, 0);
        check("ovf_sticky", overflow, 1);
        reset = 1'b0;
        #1;
        check("ovf_cleared_by_reset", overflow, 0);
        reset = 1'b1;
        cycles(1);

        // full FIFO, completing pop coincides with a new group
        out_rdy = 1'b0;
        send_group(8'h41, 8'h42, 8'h43, 8'h44, 1'b1);
        send_group(8'h51, 8'h52, 8'h53, 8'h54, 1'b1);
        check("sim_full", count, 2);
        out_rdy = 1'b1;
        cycles(3);
        check("sim_last", out_last, 1);
        send_group(8'h61, 8'h62, 8'h63, 8'h64, 1'b1);
        check("sim_no_ovf", overflow, 0);
        check("sim_count", count, 2);
        cycles(9);
        check("sim_drained", out_val, 0);

        // unsorted group
        check("oe_before", order_err, 0);
        send_group(8'h09, 8'h03, 8'h05, 8'h07, 1'b1);
        check("oe_after", order_err, EXP_OE);
        cycles(5);
        check("oe_sticky", order_err, EXP_OE);

        // reset mid-group
        send_group(8'hE1, 8'hE2, 8'hE3, 8'hE4, 1'b1);
        cycles(2);
        check("mid_idx_before_reset", out_idx, 2);
        reset = 1'b0;
        #1;
        check("mid_rst_val", out_val, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_idx", out_idx, 0);
        check("mid_rst_order_err", order_err, 0);
        exp_q.delete();
        #2;
        reset = 1'b1;
        cycles(1);
        send_group(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1);
        check("post_rst_msg", out_msg, 8'hAA);
        cycles(5);
        check("post_rst_idle", out_val, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
